// File: rtl/ip_rx_pkg.sv
// Shared types and default sizing for the IP packet receive front end.
package ip_rx_pkg;

  typedef enum logic [1:0] {
    HEADER,
    PAYLOAD,
    DRAIN
  } rx_state_t;

  typedef logic [7:0] byte_t;

  localparam int DEF_HEADER_BYTES      = 13;
  localparam int DEF_MAX_PAYLOAD_BYTES = 1500;

endpackage

// File: rtl/ip_rx_out_reg.sv
// Single-entry valid/ready register for the payload stream; reset drops any pending beat.
module ip_rx_out_reg
  import ip_rx_pkg::*;
(
  input  logic  clk,
  input  logic  srst,
  input  logic  in_valid,
  input  byte_t in_data,
  input  logic  in_last,
  output logic  in_ready,
  output logic  out_valid,
  output byte_t out_data,
  output logic  out_last,
  input  logic  out_ready
);

  logic  valid_reg;
  byte_t data_reg;
  logic  last_reg;

  // Refill in the same cycle the held beat drains, so continuous flow has no bubble.
  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = valid_reg && last_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      last_reg  <= in_last;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ip_packet_rx_byte_sequencer.sv
// Numbers incoming bytes, writes the header bytes to the capture register and forwards payload.
// Define IP_RX_STATS_EN to build the saturating good/error packet counters.
module ip_packet_rx_byte_sequencer
  import ip_rx_pkg::*;
#(
  parameter int HEADER_BYTES      = DEF_HEADER_BYTES,
  parameter int BYTE_NUM_SIZE     = 4,
  parameter int MAX_PAYLOAD_BYTES = DEF_MAX_PAYLOAD_BYTES,
  parameter int LEN_SIZE          = 11
) (
  input  logic                     CLK,
  input  logic                     ARESET,
  input  logic [7:0]               S_TDATA,
  input  logic                     S_TVALID,
  input  logic                     S_TLAST,
  output logic                     S_TREADY,
  output logic                     WR_ENABLE,
  output logic [BYTE_NUM_SIZE-1:0] WR_BYTE_NUM,
  output logic [7:0]               WR_VALUE,
  output logic                     HEADER_DONE,
  output logic [7:0]               M_TDATA,
  output logic                     M_TVALID,
  output logic                     M_TLAST,
  input  logic                     M_TREADY,
  output logic [LEN_SIZE-1:0]      PAYLOAD_LEN,
  output logic                     PKT_DONE,
  output logic                     PKT_ERROR,
  output logic [15:0]              STAT_GOOD,
  output logic [15:0]              STAT_ERR
);

  localparam logic [BYTE_NUM_SIZE-1:0] LAST_IDX = BYTE_NUM_SIZE'(HEADER_BYTES - 1);
  localparam logic [LEN_SIZE-1:0]      MAX_LEN  = LEN_SIZE'(MAX_PAYLOAD_BYTES);

  rx_state_t                state_reg, state_next;
  logic [BYTE_NUM_SIZE-1:0] idx_reg, idx_next;
  logic [LEN_SIZE-1:0]      len_reg, len_next;
  logic                     wr_enable_reg, wr_enable_next;
  logic [BYTE_NUM_SIZE-1:0] wr_byte_num_reg;
  logic [7:0]               wr_value_reg;
  logic                     header_done_reg, header_done_next;
  logic                     pkt_done_reg, pkt_done_next;
  logic                     pkt_error_reg, pkt_error_next;
  logic                     out_in_ready, fwd_valid, accept, at_last_idx, over_limit;

  assign S_TREADY    = (state_reg == PAYLOAD) ? out_in_ready : 1'b1;
  assign accept      = S_TVALID && S_TREADY;
  assign at_last_idx = (idx_reg == LAST_IDX);
  assign over_limit  = (len_reg == MAX_LEN);

  ip_rx_out_reg u_out_reg (
    .clk      (CLK),
    .srst     (ARESET),
    .in_valid (fwd_valid),
    .in_data  (S_TDATA),
    .in_last  (S_TLAST),
    .in_ready (out_in_ready),
    .out_valid(M_TVALID),
    .out_data (M_TDATA),
    .out_last (M_TLAST),
    .out_ready(M_TREADY)
  );

  always_ff @(posedge CLK) begin
    if (ARESET) state_reg <= HEADER;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HEADER:  if (accept && at_last_idx && !S_TLAST) state_next = PAYLOAD;
      PAYLOAD: if (accept) begin
                 if (over_limit)   state_next = S_TLAST ? HEADER : DRAIN;
                 else if (S_TLAST) state_next = HEADER;
               end
      DRAIN:   if (accept && S_TLAST) state_next = HEADER;
      default: state_next = HEADER;
    endcase
  end

  always_comb begin
    wr_enable_next   = 1'b0;
    header_done_next = 1'b0;
    pkt_done_next    = 1'b0;
    pkt_error_next   = 1'b0;
    fwd_valid        = 1'b0;
    idx_next         = idx_reg;
    len_next         = len_reg;
    case (state_reg)
      HEADER: if (accept) begin
        wr_enable_next = 1'b1;
        idx_next       = idx_reg + 1'b1;
        if (at_last_idx) begin
          header_done_next = 1'b1;
          pkt_done_next    = S_TLAST;
          len_next         = '0;
          idx_next         = '0;
        end else if (S_TLAST) begin
          pkt_error_next = 1'b1;
          idx_next       = '0;
        end
      end
      // The byte that would overflow the limit is dropped, so a truncated packet never gets M_TLAST.
      PAYLOAD: if (accept) begin
        if (over_limit) begin
          pkt_error_next = 1'b1;
        end else begin
          fwd_valid     = 1'b1;
          len_next      = len_reg + 1'b1;
          pkt_done_next = S_TLAST;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (ARESET) begin
      idx_reg         <= '0;
      len_reg         <= '0;
      wr_enable_reg   <= 1'b0;
      wr_byte_num_reg <= '0;
      wr_value_reg    <= '0;
      header_done_reg <= 1'b0;
      pkt_done_reg    <= 1'b0;
      pkt_error_reg   <= 1'b0;
    end else begin
      idx_reg         <= idx_next;
      len_reg         <= len_next;
      wr_enable_reg   <= wr_enable_next;
      header_done_reg <= header_done_next;
      pkt_done_reg    <= pkt_done_next;
      pkt_error_reg   <= pkt_error_next;
      if (wr_enable_next) begin
        wr_byte_num_reg <= idx_reg;
        wr_value_reg    <= S_TDATA;
      end
    end
  end

  assign WR_ENABLE   = wr_enable_reg;
  assign WR_BYTE_NUM = wr_byte_num_reg;
  assign WR_VALUE    = wr_value_reg;
  assign HEADER_DONE = header_done_reg;
  assign PKT_DONE    = pkt_done_reg;
  assign PKT_ERROR   = pkt_error_reg;
  assign PAYLOAD_LEN = len_reg;

`ifdef IP_RX_STATS_EN
  logic [1:0] stat_inc;
  assign stat_inc = {pkt_error_next, pkt_done_next};

  // Counters step alongside the registered pulse they count.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge CLK) begin
      if (ARESET)                                   cnt_reg <= '0;
      else if (stat_inc[gi] && cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign STAT_GOOD = g_stat[0].cnt_reg;
  assign STAT_ERR  = g_stat[1].cnt_reg;
`else
  assign STAT_GOOD = '0;
  assign STAT_ERR  = '0;
`endif

endmodule
